// File: rtl/fib_ctrl_pkg.sv
// fib_ctrl_pkg
// Shared constants and types for the Wishbone-facing fibonacci controller:
// the register window base, the register offsets inside it, the CTRL and
// STATUS bit positions, the core latency offset, the largest operand whose
// result fits in 32 bits, and the controller FSM state type.
package fib_ctrl_pkg;

  // 16-byte register window
  localparam logic [31:0] BASE_ADDR = 32'h3000_0000;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_N      = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_RESULT = 4'hC;

  // CTRL bits
  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;

  // STATUS bits
  localparam int unsigned STAT_BUSY_BIT = 0;
  localparam int unsigned STAT_DONE_BIT = 1;
  localparam int unsigned STAT_ERR_BIT  = 2;

  // Core cycles beyond n before its result is valid
  localparam int unsigned LAT_OFFSET = 2;

  // Largest n whose fibonacci number fits in 32 bits
  localparam int unsigned N_MAX = 47;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/fib_wb_if.sv
// fib_wb_if
// Wishbone classic slave bus bundle for the fibonacci controller.
//   wbs_cyc_i, wbs_stb_i, wbs_we_i : cycle, strobe, write enable
//   wbs_sel_i [3:0]                : byte enables
//   wbs_adr_i [31:0]               : byte address
//   wbs_dat_i [31:0]               : write data
//   wbs_dat_o [31:0]               : read data (zero when no ack)
//   wbs_ack_o                      : single-cycle transfer acknowledge
// The master modport is the bus side (CPU/testbench), slave is the block.
interface fib_wb_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o
  );

endinterface

// File: rtl/fib_wb_ctrl.sv
// fib_wb_ctrl
// Wishbone register front-end for an external fibonacci core. Software
// writes the operand n, starts a job through CTRL, and collects the result
// from RESULT once STATUS.done is set (optionally via irq_o).
//
// Ports
//   wb_clk_i   : system clock
//   wb_rst_ni  : synchronous active-low reset
//   wb         : Wishbone classic slave bundle (fib_wb_if.slave)
//   irq_o      : completion interrupt, level (done & irq_en)
//   core_st_o  : one-cycle start pulse to the core
//   core_n_o   : operand to the core, always the N register
//   core_fn_i  : core result, sampled when the latency counter expires
//
// Register map (offsets from BASE_ADDR)
//   0x0 CTRL   : bit1 irq_en (rw), bit0 start (write-only, reads 0)
//   0x4 N      : bits[7:0] operand, writable only when idle
//   0x8 STATUS : bit2 err (W1C), bit1 done (W1C), bit0 busy (ro)
//   0xC RESULT : last result (ro)
module fib_wb_ctrl
  import fib_ctrl_pkg::*;
(
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  fib_wb_if.slave     wb,
  output logic        irq_o,
  output logic        core_st_o,
  output logic [7:0]  core_n_o,
  input  logic [31:0] core_fn_i
);

  localparam logic [7:0] N_MAX_8      = 8'(N_MAX);
  localparam logic [8:0] LAT_OFFSET_9 = 9'(LAT_OFFSET);

  fsm_state_e  state;
  logic [8:0]  cnt;
  logic [7:0]  n;
  logic [31:0] result;
  logic        irq_en;
  logic        done;
  logic        err;

  logic        busy;
  logic        hit;
  logic        acc;
  logic        wr;
  logic        rd;
  logic        ctrl_wr;
  logic        n_wr;
  logic        stat_wr;
  logic        start_req;
  logic        n_ok;
  logic        start_go;
  logic        err_set;
  logic        done_set;
  logic [31:0] rdata;

  // Write data above bit 7 and the upper byte enables carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{wb.wbs_dat_i[31:8], wb.wbs_sel_i[3:1]};

  assign busy = (state != ST_IDLE);

  // Bus decode. acc is true on exactly the edge where ack rises: a hit while
  // ack is low. Holding stb therefore yields ack every other cycle, and each
  // register side effect happens once per acknowledged transfer.
  assign hit     = wb.wbs_cyc_i & wb.wbs_stb_i &
                   (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign acc     = hit & ~wb.wbs_ack_o;
  assign wr      = acc & wb.wbs_we_i;
  assign rd      = acc & ~wb.wbs_we_i;
  assign ctrl_wr = wr & (wb.wbs_adr_i[3:0] == OFF_CTRL) & wb.wbs_sel_i[0];
  assign n_wr    = wr & (wb.wbs_adr_i[3:0] == OFF_N)    & wb.wbs_sel_i[0];
  assign stat_wr = wr & (wb.wbs_adr_i[3:0] == OFF_STATUS);

  assign start_req = ctrl_wr & wb.wbs_dat_i[CTRL_START_BIT];
  assign n_ok      = (n <= N_MAX_8);
  assign start_go  = start_req & ~busy & n_ok;
  // Rejected requests: start while running or with an oversize operand,
  // and operand rewrites while running.
  assign err_set   = (start_req & (busy | ~n_ok)) | (n_wr & busy);
  assign done_set  = (state == ST_WAIT) & (cnt == 9'd0);

  assign core_n_o = n;
  assign irq_o    = done & irq_en;

  // Read mux.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rdata = '0;
    unique case (wb.wbs_adr_i[3:0])
      OFF_CTRL:   rdata[CTRL_IRQ_EN_BIT] = irq_en;
      OFF_N:      rdata[7:0]             = n;
      OFF_STATUS: begin
        rdata[STAT_BUSY_BIT] = busy;
        rdata[STAT_DONE_BIT] = done;
        rdata[STAT_ERR_BIT]  = err;
      end
      OFF_RESULT: rdata = result;
      default:    rdata = '0;
    endcase
  end

  // Bus-side registers: ack, read data, irq_en and the operand.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
      irq_en       <= 1'b0;
      n            <= '0;
    end else begin
      wb.wbs_ack_o <= acc;
      wb.wbs_dat_o <= rd ? rdata : '0;
      if (ctrl_wr) irq_en <= wb.wbs_dat_i[CTRL_IRQ_EN_BIT];
      if (n_wr && !busy) n <= wb.wbs_dat_i[7:0];
    end
  end

  // Job FSM with registered start pulse, plus the done/err status flags.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      result    <= '0;
      core_st_o <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      core_st_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start_go) begin
            state     <= ST_START;
            core_st_o <= 1'b1;
          end
        end
        ST_START: begin
          cnt   <= {1'b0, n} + LAT_OFFSET_9;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt != 9'd0) begin
            cnt <= cnt - 9'd1;
          end else begin
            result <= core_fn_i;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Set has priority over a same-edge W1C clear. start_go only fires in
      // IDLE and done_set only in WAIT, so they never collide.
      if (start_go) begin
        done <= 1'b0;
      end else if (done_set) begin
        done <= 1'b1;
      end else if (stat_wr && wb.wbs_dat_i[STAT_DONE_BIT]) begin
        done <= 1'b0;
      end

      if (err_set) begin
        err <= 1'b1;
      end else if (stat_wr && wb.wbs_dat_i[STAT_ERR_BIT]) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fib_wb_ctrl.sv
// tb_fib_wb_ctrl
// Bench for fib_wb_ctrl. A behavioural fibonacci core drives core_fn_i with
// a poison value until n+LAT_OFFSET cycles after the start pulse, so a
// controller that samples early captures garbage. Register reads push their
// expected value to a scoreboard queue and are compared when ack arrives.
module tb_fib_wb_ctrl;
  import fib_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        irq;
  logic        core_st;
  logic [7:0]  core_n;
  logic [31:0] core_fn;

  fib_wb_if bus ();

  fib_wb_ctrl dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wb        (bus),
    .irq_o     (irq),
    .core_st_o (core_st),
    .core_n_o  (core_n),
    .core_fn_i (core_fn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural fibonacci core ----------------
  function automatic logic [31:0] fib(input int k);
    logic [31:0] a, b, t;
    a = 32'd0;
    b = 32'd1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  int core_k = 400;
  int core_nn = 0;
  int st_pulses = 0;
  initial core_fn = 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (core_st) begin
      core_k   <= 0;
      core_nn  <= int'(core_n);
      core_fn  <= 32'hDEAD_BEEF;
      st_pulses <= st_pulses + 1;
    end else if (core_k < 400) begin
      core_k <= core_k + 1;
      if (core_k + 1 >= core_nn + int'(LAT_OFFSET)) core_fn <= fib(core_nn);
    end
  end

  // ---------------- bus tasks ----------------
  task automatic wb_xfer(input logic we, input logic [3:0] off,
                         input logic [3:0] sel, input logic [31:0] data,
                         output logic [31:0] rdat, output bit ok);
    ok = 1'b0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = BASE_ADDR | {28'h0, off};
    bus.wbs_dat_i = data;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (bus.wbs_ack_o) ok = 1'b1;
    end
    rdat = bus.wbs_dat_o;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [3:0] off, input logic [3:0] sel,
                          input logic [31:0] data, input string name);
    logic [31:0] d;
    bit ok;
    wb_xfer(1'b1, off, sel, data, d, ok);
    check({name, "_ack"}, 32'(ok), 32'd1);
  endtask

  task automatic wb_read(input logic [3:0] off, input logic [31:0] exp,
                         input string name);
    logic [31:0] d;
    logic [31:0] e;
    bit ok;
    exp_q.push_back(exp);
    wb_xfer(1'b0, off, 4'hF, 32'h0, d, ok);
    e = exp_q.pop_front();
    if (!ok) check({name, "_ack"}, 32'(ok), 32'd1);
    else     check(name, d, e);
  endtask

  task automatic wait_done(input string name);
    logic [31:0] d;
    bit ok;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      wb_xfer(1'b0, OFF_STATUS, 4'hF, 32'h0, d, ok);
      if (ok && d[STAT_DONE_BIT]) seen = 1'b1;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  // ---------------- register vector table ----------------
  typedef struct {
    logic        we;
    logic [3:0]  off;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic set_vec(input int i, input logic we, input logic [3:0] off,
                         input logic [3:0] sel, input logic [31:0] data,
                         input logic [31:0] exp, input string name);
    vecs[i].we   = we;
    vecs[i].off  = off;
    vecs[i].sel  = sel;
    vecs[i].data = data;
    vecs[i].exp  = exp;
    vecs[i].name = name;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int acks, consec, p0;
    logic prev;

    set_vec(0,  1'b0, OFF_CTRL,   4'hF, 32'h0,         32'h0,  "rst_ctrl");
    set_vec(1,  1'b0, OFF_N,      4'hF, 32'h0,         32'h0,  "rst_n_reg");
    set_vec(2,  1'b0, OFF_STATUS, 4'hF, 32'h0,         32'h0,  "rst_status");
    set_vec(3,  1'b0, OFF_RESULT, 4'hF, 32'h0,         32'h0,  "rst_result");
    set_vec(4,  1'b1, OFF_CTRL,   4'hF, 32'h2,         32'h0,  "w_irq_en");
    set_vec(5,  1'b0, OFF_CTRL,   4'hF, 32'h0,         32'h2,  "r_irq_en");
    set_vec(6,  1'b1, OFF_N,      4'hF, 32'hFFFF_FF2A, 32'h0,  "w_n_2a");
    set_vec(7,  1'b0, OFF_N,      4'hF, 32'h0,         32'h2A, "r_n_2a");
    set_vec(8,  1'b1, OFF_N,      4'hE, 32'h5,         32'h0,  "w_n_nosel");
    set_vec(9,  1'b0, OFF_N,      4'hF, 32'h0,         32'h2A, "r_n_nosel");
    set_vec(10, 1'b1, OFF_CTRL,   4'hE, 32'h0,         32'h0,  "w_ctrl_nosel");
    set_vec(11, 1'b0, OFF_CTRL,   4'hF, 32'h0,         32'h2,  "r_ctrl_nosel");
    set_vec(12, 1'b1, OFF_RESULT, 4'hF, 32'hFFFF_FFFF, 32'h0,  "w_result_ro");
    set_vec(13, 1'b0, OFF_RESULT, 4'hF, 32'h0,         32'h0,  "r_result_ro");
    set_vec(14, 1'b1, OFF_STATUS, 4'hF, 32'h1,         32'h0,  "w_busy_ro");
    set_vec(15, 1'b0, OFF_STATUS, 4'hF, 32'h0,         32'h0,  "r_busy_ro");
    set_vec(16, 1'b1, OFF_CTRL,   4'hF, 32'h0,         32'h0,  "w_irq_off");
    set_vec(17, 1'b0, OFF_CTRL,   4'hF, 32'h0,         32'h0,  "r_irq_off");

    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state of the outputs
    check("rst_ack",     32'(bus.wbs_ack_o), 32'd0);
    check("rst_dat_o",   bus.wbs_dat_o,      32'd0);
    check("rst_irq",     32'(irq),           32'd0);
    check("rst_core_st", 32'(core_st),       32'd0);
    check("rst_core_n",  32'(core_n),        32'd0);

    // Register access table
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].we) wb_write(vecs[i].off, vecs[i].sel, vecs[i].data, vecs[i].name);
      else            wb_read(vecs[i].off, vecs[i].exp, vecs[i].name);
    end
    check("core_n_follows_n", 32'(core_n), 32'h2A);

    // Non-hit addresses are never acked
    @(posedge clk);
    #1;
    acks = 0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_adr_i = BASE_ADDR + 32'h10;
    repeat (4) begin @(posedge clk); #1; if (bus.wbs_ack_o) acks++; end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_adr_i = BASE_ADDR;
    repeat (4) begin @(posedge clk); #1; if (bus.wbs_ack_o) acks++; end
    bus.wbs_stb_i = 1'b0;
    check("nohit_acks", 32'(acks), 32'd0);

    // Held strobe: ack toggles, never on two consecutive cycles
    acks = 0;
    consec = 0;
    prev = 1'b0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = BASE_ADDR | 32'(OFF_STATUS);
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.wbs_ack_o) acks++;
      if (bus.wbs_ack_o && prev) consec++;
      prev = bus.wbs_ack_o;
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    check("held_stb_acks",   32'(acks),   32'd3);
    check("held_stb_consec", 32'(consec), 32'd0);
    @(posedge clk);
    #1;

    // n=10: one-cycle start pulse, done/irq exactly 14 edges after ack
    wb_write(OFF_N, 4'hF, 32'd10, "n10_w_n");
    wb_write(OFF_CTRL, 4'hF, 32'h3, "n10_w_ctrl");
    check("n10_st_high", 32'(core_st), 32'd1);
    @(posedge clk);
    #1;
    check("n10_st_low", 32'(core_st), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("n10_irq_edge13", 32'(irq), 32'd0);
    @(posedge clk);
    #1;
    check("n10_irq_edge14", 32'(irq), 32'd1);
    wb_read(OFF_RESULT, 32'd55, "n10_result");
    @(posedge clk);
    #1;
    check("dat_o_zero_no_ack", bus.wbs_dat_o, 32'd0);
    wb_read(OFF_STATUS, 32'h2, "n10_status");

    // n=47: largest legal operand
    wb_write(OFF_STATUS, 4'hF, 32'h6, "n47_clr");
    wb_write(OFF_N, 4'hF, 32'd47, "n47_w_n");
    wb_write(OFF_CTRL, 4'hF, 32'h1, "n47_w_ctrl");
    wait_done("n47");
    wb_read(OFF_RESULT, 32'hB119_24E1, "n47_result");
    wb_read(OFF_STATUS, 32'h2, "n47_status");

    // n=48: rejected start
    wb_write(OFF_STATUS, 4'hF, 32'h6, "n48_clr");
    p0 = st_pulses;
    wb_write(OFF_N, 4'hF, 32'd48, "n48_w_n");
    check("n48_core_n", 32'(core_n), 32'd48);
    wb_write(OFF_CTRL, 4'hF, 32'h1, "n48_w_ctrl");
    check("n48_st_now", 32'(core_st), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("n48_no_pulse", 32'(st_pulses), 32'(p0));
    wb_read(OFF_STATUS, 32'h4, "n48_status");
    wb_read(OFF_RESULT, 32'hB119_24E1, "n48_result");

    // n=20 with N write and restart attempts while busy
    wb_write(OFF_STATUS, 4'hF, 32'h6, "n20_clr");
    p0 = st_pulses;
    wb_write(OFF_N, 4'hF, 32'd20, "n20_w_n");
    wb_write(OFF_CTRL, 4'hF, 32'h1, "n20_w_ctrl");
    wb_write(OFF_N, 4'hF, 32'd5, "n20_w_n_busy");
    wb_write(OFF_CTRL, 4'hF, 32'h1, "n20_w_ctrl_busy");
    wb_read(OFF_N, 32'd20, "n20_n_kept");
    check("n20_core_n", 32'(core_n), 32'd20);
    wb_read(OFF_STATUS, 32'h5, "n20_status_busy");
    wait_done("n20");
    wb_read(OFF_RESULT, 32'd6765, "n20_result");
    wb_read(OFF_STATUS, 32'h6, "n20_status_end");
    check("n20_one_pulse", 32'(st_pulses), 32'(p0 + 1));

    // W1C of done on the completion edge: set wins
    wb_write(OFF_STATUS, 4'hF, 32'h6, "w1c_clr");
    wb_write(OFF_N, 4'hF, 32'd10, "w1c_w_n");
    @(posedge clk);
    #1;
    wb_write(OFF_CTRL, 4'hF, 32'h3, "w1c_w_ctrl");
    repeat (13) @(posedge clk);
    #1;
    wb_write(OFF_STATUS, 4'hF, 32'h2, "w1c_w_done_edge");
    wb_read(OFF_STATUS, 32'h2, "w1c_done_kept");
    check("w1c_irq_kept", 32'(irq), 32'd1);
    wb_write(OFF_STATUS, 4'hF, 32'h6, "w1c_w_clear");
    wb_read(OFF_STATUS, 32'h0, "w1c_cleared");
    check("w1c_irq_cleared", 32'(irq), 32'd0);

    // Reset mid-WAIT
    wb_write(OFF_N, 4'hF, 32'd30, "rst_w_n");
    wb_write(OFF_CTRL, 4'hF, 32'h3, "rst_w_ctrl");
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_ack",     32'(bus.wbs_ack_o), 32'd0);
    check("midrst_dat_o",   bus.wbs_dat_o,      32'd0);
    check("midrst_irq",     32'(irq),           32'd0);
    check("midrst_core_st", 32'(core_st),       32'd0);
    check("midrst_core_n",  32'(core_n),        32'd0);
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("postrst_irq", 32'(irq), 32'd0);
    wb_read(OFF_STATUS, 32'h0, "postrst_status");
    wb_read(OFF_RESULT, 32'h0, "postrst_result");
    wb_read(OFF_CTRL,   32'h0, "postrst_ctrl");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
